cu_multi_cycle: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle control unit for the MIPS-subset CPU.
- Moore/Mealy FSM that sequences FETCH, DECODE, EXEC, MEM and WB per instruction class.
- Adds wait-state handshake with a shared instruction/data memory (mem_ready) and a configurable multi-cycle multiply.
- Flags unsupported opcodes instead of silently decoding them as ALU ops.

---
 rtl/cu_multi_cycle_if.sv | 40 ++++
 rtl/cu_multi_cycle.sv | 237 +++++++++++++++++++++++
 tb/tb_cu_multi_cycle.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cu_multi_cycle_if.sv
// Control bus between the multi-cycle control unit and the datapath/memory.
// The master side is the control unit; the slave side is the datapath.
interface cu_multi_cycle_if #(
  parameter int ALUCTRL_W = 5
);
  logic [5:0]           op;
  logic [5:0]           func;
  logic                 zero;
  logic                 mem_ready;
  logic                 MemRead;
  logic                 IorD;
  logic                 IRWrite;
  logic                 PCWrite;
  logic [1:0]           Branch;
  logic                 MemWrite;
  logic                 MemtoReg;
  logic                 RegWrite;
  logic [1:0]           RegDst;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 ALUSrcA;
  logic                 ALUSrcB;
  logic                 Extend;
  logic                 PCtoReg;
  logic                 busy;
  logic                 illegal;

  modport master (
    input  op, func, zero, mem_ready,
    output MemRead, IorD, IRWrite, PCWrite, Branch, MemWrite, MemtoReg,
           RegWrite, RegDst, ALUControl, ALUSrcA, ALUSrcB, Extend, PCtoReg,
           busy, illegal
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  MemRead, IorD, IRWrite, PCWrite, Branch, MemWrite, MemtoReg,
           RegWrite, RegDst, ALUControl, ALUSrcA, ALUSrcB, Extend, PCtoReg,
           busy, illegal
  );
endinterface

// File: rtl/cu_multi_cycle.sv
// Multi-cycle control unit for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB
// sequencing with memory wait states, multi-cycle mul and illegal-op flagging.
module cu_multi_cycle #(
  parameter int ALUCTRL_W     = 5,
  parameter int MUL_CYCLES    = 4,
  parameter int FETCH_TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           rst,
  cu_multi_cycle_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [3:0] {
    K_BAD,
    K_ALU,
    K_MUL,
    K_IMM,
    K_LW,
    K_SW,
    K_BR,
    K_J,
    K_JR,
    K_JAL
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [4:0] alu;
    logic       ext;
    logic       src_a;
    logic       src_b;
  } dec_t;

  localparam int MC_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int MC_LAST = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 0;
  localparam int FT_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam int FT_LAST = (FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] func);
    dec_t d;
    d = '{kind: K_IMM, alu: 5'b00000, ext: 1'b0, src_a: 1'b0, src_b: 1'b1};
    case (op)
      6'b000000: begin
        d.kind  = K_ALU;
        d.src_b = 1'b0;
        case (func)
          6'b100000: d.alu = 5'b00000;
          6'b100001: d.alu = 5'b00001;
          6'b100010: d.alu = 5'b00010;
          6'b100011: d.alu = 5'b00011;
          6'b100100: d.alu = 5'b00100;
          6'b100101: d.alu = 5'b00101;
          6'b100110: d.alu = 5'b00110;
          6'b100111: d.alu = 5'b00111;
          6'b101010: d.alu = 5'b01000;
          6'b101011: d.alu = 5'b01001;
          6'b000000: begin d.alu = 5'b01010; d.src_a = 1'b1; end
          6'b000010: begin d.alu = 5'b01011; d.src_a = 1'b1; end
          6'b000011: begin d.alu = 5'b01100; d.src_a = 1'b1; end
          6'b000100: d.alu = 5'b01010;
          6'b000110: d.alu = 5'b01011;
          6'b000111: d.alu = 5'b01100;
          6'b001000: begin d.kind = K_JR; d.alu = 5'b11111; end
          default:   d.kind = K_BAD;
        endcase
      end
      6'b011100: begin
        d.src_b = 1'b0;
        d.alu   = 5'b10000;
        d.kind  = (func == 6'b000010) ? K_MUL : K_BAD;
      end
      6'b100011: begin d.kind = K_LW; d.ext = 1'b1; end
      6'b101011: begin d.kind = K_SW; d.ext = 1'b1; end
      6'b000100: begin d.kind = K_BR; d.alu = 5'b01101; d.ext = 1'b1; d.src_b = 1'b0; end
      6'b000101: begin d.kind = K_BR; d.alu = 5'b01110; d.ext = 1'b1; d.src_b = 1'b0; end
      6'b001000: begin d.alu = 5'b00000; d.ext = 1'b1; end
      6'b001001: begin d.alu = 5'b00001; d.ext = 1'b1; end
      6'b001010: begin d.alu = 5'b01000; d.ext = 1'b1; end
      6'b001011: begin d.alu = 5'b01001; d.ext = 1'b1; end
      6'b001100: d.alu = 5'b00100;
      6'b001101: d.alu = 5'b00101;
      6'b001110: d.alu = 5'b00110;
      6'b001111: d.alu = 5'b01111;
      6'b000010: begin d.kind = K_J;   d.alu = 5'b11111; d.src_b = 1'b0; end
      6'b000011: begin d.kind = K_JAL; d.alu = 5'b11111; d.src_b = 1'b0; end
      default:   d.kind = K_BAD;
    endcase
    return d;
  endfunction

  state_e           state;
  dec_t             dec;
  dec_t             cur;
  logic [MC_W-1:0]  mul_cnt;
  logic [FT_W-1:0]  fetch_cnt;
  logic             mul_done;
  logic             fetch_timeout;

  always_comb dec = decode(bus.op, bus.func);

  assign mul_done      = (mul_cnt == MC_W'(MC_LAST));
  assign fetch_timeout = (FETCH_TIMEOUT > 0) && !bus.mem_ready &&
                         (fetch_cnt == FT_W'(FT_LAST));

  // The decoded form of op/func is latched in DECODE so EXEC/MEM/WB no longer
  // depend on the IR after it has been consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      cur       <= '0;
      mul_cnt   <= '0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            state     <= S_DECODE;
            fetch_cnt <= '0;
          end else if (fetch_timeout) begin
            fetch_cnt <= '0;
          end else if (FETCH_TIMEOUT > 0) begin
            fetch_cnt <= fetch_cnt + FT_W'(1);
          end
        end
        S_DECODE: begin
          mul_cnt <= '0;
          if (dec.kind == K_BAD) begin
            state <= S_FETCH;
          end else begin
            cur   <= dec;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cur.kind)
            K_BR, K_J, K_JR: state <= S_FETCH;
            K_LW, K_SW:      state <= S_MEM;
            K_MUL: begin
              if (mul_done) state <= S_WB;
              else          mul_cnt <= mul_cnt + MC_W'(1);
            end
            default:         state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) state <= (cur.kind == K_SW) ? S_FETCH : S_WB;
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode straight from the registered state so that reset kills
  // every strobe immediately; only MemRead survives reset (FETCH).
  always_comb begin
    bus.MemRead    = (state == S_FETCH);
    bus.IorD       = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 2'b00;
    bus.MemWrite   = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 2'b00;
    bus.ALUControl = '0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 1'b0;
    bus.Extend     = 1'b0;
    bus.PCtoReg    = 1'b0;
    bus.busy       = (state != S_FETCH);
    bus.illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
          end else if (fetch_timeout) begin
            bus.illegal = 1'b1;
          end
        end
        S_DECODE: bus.illegal = (dec.kind == K_BAD);
        S_EXEC: begin
          bus.ALUControl = ALUCTRL_W'(cur.alu);
          bus.ALUSrcA    = cur.src_a;
          bus.ALUSrcB    = cur.src_b;
          bus.Extend     = cur.ext;
          case (cur.kind)
            K_BR: begin
              if (bus.zero) begin
                bus.PCWrite = 1'b1;
                bus.Branch  = 2'b01;
              end
            end
            K_J, K_JAL: begin
              bus.PCWrite = 1'b1;
              bus.Branch  = 2'b10;
            end
            K_JR: begin
              bus.PCWrite = 1'b1;
              bus.Branch  = 2'b11;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.IorD     = 1'b1;
          bus.MemRead  = (cur.kind == K_LW);
          bus.MemWrite = (cur.kind == K_SW);
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          case (cur.kind)
            K_ALU, K_MUL: bus.RegDst = 2'b01;
            K_JAL: begin
              bus.RegDst  = 2'b10;
              bus.PCtoReg = 1'b1;
            end
            K_LW:    bus.MemtoReg = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_multi_cycle.sv
// Self-checking bench for cu_multi_cycle: directed and random instructions
// checked cycle by cycle against an instruction-table reference model.
module tb_cu_multi_cycle;

  localparam int MUL_N = 4;
  localparam int TO_N  = 3;

  typedef struct packed {
    logic       mem_read;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] branch;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [4:0] alu;
    logic       src_a;
    logic       src_b;
    logic       ext;
    logic       pc_to_reg;
    logic       busy;
    logic       illegal;
  } ov_t;

  // cls: R=reg ALU, M=mul, I=imm, L=lw, S=sw, B=branch, J=j, A=jal, X=jr
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] alu;
    logic       ext;
    logic       sa;
    logic       sb;
    byte        cls;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  ent_t tbl[$];

  always #5 clk = ~clk;

  cu_multi_cycle_if #(.ALUCTRL_W(5)) bus ();

  cu_multi_cycle #(
    .ALUCTRL_W    (5),
    .MUL_CYCLES   (MUL_N),
    .FETCH_TIMEOUT(TO_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic void add(input string n, input logic [5:0] o, input logic [5:0] f,
                              input logic [4:0] a, input logic x, input logic sa,
                              input logic sb, input byte c);
    ent_t t;
    t.name = n; t.op = o; t.func = f; t.alu = a; t.ext = x; t.sa = sa; t.sb = sb; t.cls = c;
    tbl.push_back(t);
  endfunction

  function automatic bit lookup(input logic [5:0] o, input logic [5:0] f, output ent_t r);
    r = tbl[0];
    foreach (tbl[i]) begin
      if (tbl[i].op == o && ((o != 6'h00 && o != 6'h1c) || tbl[i].func == f)) begin
        r = tbl[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic ov_t observe();
    ov_t v;
    v.mem_read = bus.MemRead;   v.iord = bus.IorD;         v.ir_write = bus.IRWrite;
    v.pc_write = bus.PCWrite;   v.branch = bus.Branch;     v.mem_write = bus.MemWrite;
    v.mem_to_reg = bus.MemtoReg; v.reg_write = bus.RegWrite; v.reg_dst = bus.RegDst;
    v.alu = bus.ALUControl;     v.src_a = bus.ALUSrcA;     v.src_b = bus.ALUSrcB;
    v.ext = bus.Extend;         v.pc_to_reg = bus.PCtoReg; v.busy = bus.busy;
    v.illegal = bus.illegal;
    return v;
  endfunction

  task automatic chk(input ov_t e, input string tag);
    ov_t o;
    o = observe();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cyc(input logic mr, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input ov_t e, input string tag);
    @(negedge clk);
    bus.op = o; bus.func = f; bus.zero = z; bus.mem_ready = mr;
    #1;
    chk(e, tag);
  endtask

  // One instruction from FETCH back to the next FETCH, expected outputs built
  // from the instruction table and the per-class sequencing rules.
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input int fw, input int mw, input bit abort_mem, input string tag);
    ent_t en;
    bit   ok;
    ov_t  e;
    int   n;
    ok = lookup(o, f, en);
    for (int w = 0; w < fw; w++) begin
      e = '0; e.mem_read = 1'b1; e.illegal = ((w + 1) % TO_N == 0);
      cyc(1'b0, 6'($urandom), 6'($urandom), 1'($urandom), e, {tag, "/fetch_wait"});
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), e, {tag, "/fetch"});
    e = '0; e.busy = 1'b1; e.illegal = !ok;
    cyc(1'($urandom), o, f, z, e, {tag, "/decode"});
    if (!ok) return;
    n = (en.cls == "M") ? MUL_N : 1;
    for (int k = 0; k < n; k++) begin
      e = '0; e.busy = 1'b1; e.alu = en.alu; e.src_a = en.sa; e.src_b = en.sb; e.ext = en.ext;
      if ((en.cls == "B" && z) || en.cls == "J" || en.cls == "A" || en.cls == "X") e.pc_write = 1'b1;
      if (en.cls == "B" && z) e.branch = 2'b01;
      if (en.cls == "J" || en.cls == "A") e.branch = 2'b10;
      if (en.cls == "X") e.branch = 2'b11;
      cyc(1'($urandom), o, f, z, e, {tag, "/exec"});
    end
    if (en.cls == "L" || en.cls == "S") begin
      e = '0; e.busy = 1'b1; e.iord = 1'b1;
      e.mem_read = (en.cls == "L"); e.mem_write = (en.cls == "S");
      for (int w = 0; w < mw; w++) begin
        cyc(1'b0, o, f, z, e, {tag, "/mem_wait"});
        if (abort_mem) begin
          #2 rst = 1'b1;
          #1;
          e = '0; e.mem_read = 1'b1;
          chk(e, {tag, "/rst_async"});
          @(negedge clk); bus.mem_ready = 1'b1; #1;
          chk(e, {tag, "/rst_held"});
          @(negedge clk); rst = 1'b0; bus.mem_ready = 1'b0; #1;
          chk(e, {tag, "/rst_release"});
          return;
        end
      end
      cyc(1'b1, o, f, z, e, {tag, "/mem"});
    end
    if (en.cls inside {"R", "M", "I", "L", "A"}) begin
      e = '0; e.busy = 1'b1; e.reg_write = 1'b1;
      e.reg_dst = (en.cls == "R" || en.cls == "M") ? 2'b01 : (en.cls == "A") ? 2'b10 : 2'b00;
      e.mem_to_reg = (en.cls == "L"); e.pc_to_reg = (en.cls == "A");
      cyc(1'($urandom), o, f, z, e, {tag, "/wb"});
    end
  endtask

  initial begin
    ov_t e;
    ent_t pick;
    add("add", 6'h00, 6'h20, 5'h00, 0, 0, 0, "R"); add("addu", 6'h00, 6'h21, 5'h01, 0, 0, 0, "R");
    add("sub", 6'h00, 6'h22, 5'h02, 0, 0, 0, "R"); add("subu", 6'h00, 6'h23, 5'h03, 0, 0, 0, "R");
    add("and", 6'h00, 6'h24, 5'h04, 0, 0, 0, "R"); add("or",   6'h00, 6'h25, 5'h05, 0, 0, 0, "R");
    add("xor", 6'h00, 6'h26, 5'h06, 0, 0, 0, "R"); add("nor",  6'h00, 6'h27, 5'h07, 0, 0, 0, "R");
    add("slt", 6'h00, 6'h2a, 5'h08, 0, 0, 0, "R"); add("sltu", 6'h00, 6'h2b, 5'h09, 0, 0, 0, "R");
    add("sll", 6'h00, 6'h00, 5'h0a, 0, 1, 0, "R"); add("srl",  6'h00, 6'h02, 5'h0b, 0, 1, 0, "R");
    add("sra", 6'h00, 6'h03, 5'h0c, 0, 1, 0, "R"); add("sllv", 6'h00, 6'h04, 5'h0a, 0, 0, 0, "R");
    add("srlv", 6'h00, 6'h06, 5'h0b, 0, 0, 0, "R"); add("srav", 6'h00, 6'h07, 5'h0c, 0, 0, 0, "R");
    add("jr",  6'h00, 6'h08, 5'h1f, 0, 0, 0, "X"); add("mul",  6'h1c, 6'h02, 5'h10, 0, 0, 0, "M");
    add("lw",  6'h23, 6'h00, 5'h00, 1, 0, 1, "L"); add("sw",   6'h2b, 6'h00, 5'h00, 1, 0, 1, "S");
    add("beq", 6'h04, 6'h00, 5'h0d, 1, 0, 0, "B"); add("bne",  6'h05, 6'h00, 5'h0e, 1, 0, 0, "B");
    add("addi", 6'h08, 6'h00, 5'h00, 1, 0, 1, "I"); add("addiu", 6'h09, 6'h00, 5'h01, 1, 0, 1, "I");
    add("slti", 6'h0a, 6'h00, 5'h08, 1, 0, 1, "I"); add("sltiu", 6'h0b, 6'h00, 5'h09, 1, 0, 1, "I");
    add("andi", 6'h0c, 6'h00, 5'h04, 0, 0, 1, "I"); add("ori",  6'h0d, 6'h00, 5'h05, 0, 0, 1, "I");
    add("xori", 6'h0e, 6'h00, 5'h06, 0, 0, 1, "I"); add("lui",  6'h0f, 6'h00, 5'h0f, 0, 0, 1, "I");
    add("j",   6'h02, 6'h00, 5'h1f, 0, 0, 0, "J"); add("jal",  6'h03, 6'h00, 5'h1f, 0, 0, 0, "A");

    rst = 1'b1;
    bus.op = 6'h2b; bus.func = 6'h00; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    #3;
    e = '0; e.mem_read = 1'b1;
    chk(e, "reset");
    @(negedge clk); rst = 1'b0; bus.mem_ready = 1'b0; #1;
    chk(e, "reset_release");

    run(6'h00, 6'h20, 1'b0, 0, 0, 1'b0, "add");
    run(6'h23, 6'h11, 1'b0, 0, 2, 1'b0, "lw_wait2");
    run(6'h04, 6'h05, 1'b1, 0, 0, 1'b0, "beq_taken");
    run(6'h04, 6'h05, 1'b0, 0, 0, 1'b0, "beq_not_taken");
    run(6'h05, 6'h3a, 1'b1, 0, 0, 1'b0, "bne_taken");
    run(6'h03, 6'h2a, 1'b0, 0, 0, 1'b0, "jal");
    run(6'h1c, 6'h02, 1'b0, 0, 0, 1'b0, "mul");
    run(6'h3f, 6'h00, 1'b0, 0, 0, 1'b0, "illegal_op");
    run(6'h1c, 6'h03, 1'b0, 0, 0, 1'b0, "illegal_mul_func");
    run(6'h00, 6'h01, 1'b0, 0, 0, 1'b0, "illegal_rfunc");
    run(6'h00, 6'h00, 1'b0, 0, 0, 1'b0, "sll");
    run(6'h00, 6'h08, 1'b0, 0, 0, 1'b0, "jr");
    run(6'h0f, 6'h3f, 1'b0, 0, 0, 1'b0, "lui");
    run(6'h0b, 6'h00, 1'b0, 0, 0, 1'b0, "sltiu");
    run(6'h02, 6'h00, 1'b1, 0, 0, 1'b0, "j");
    run(6'h00, 6'h20, 1'b0, 4, 0, 1'b0, "fetch_timeout");
    run(6'h0d, 6'h00, 1'b0, 2, 0, 1'b0, "fetch_wait2_a");
    run(6'h00, 6'h21, 1'b0, 2, 0, 1'b0, "fetch_wait2_b");
    run(6'h2b, 6'h00, 1'b0, 0, 3, 1'b1, "sw_rst_abort");
    run(6'h00, 6'h26, 1'b0, 0, 0, 1'b0, "xor_after_rst");

    for (int i = 0; i < 80; i++) begin
      logic [5:0] o, f;
      if ($urandom_range(0, 7) == 0) begin
        o = 6'($urandom);
        f = 6'($urandom);
      end else begin
        pick = tbl[$urandom_range(0, tbl.size() - 1)];
        o = pick.op;
        f = (o == 6'h00 || o == 6'h1c) ? pick.func : 6'($urandom);
      end
      run(o, f, 1'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
          1'b0, $sformatf("rand%0d_op%02h_f%02h", i, o, f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
